// File: rtl/exu_md_pkg.sv
// Shared opcode/state encodings for the execute stage and its iterative
// multiply/divide engine.
package exu_md_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIV  = 4'd11,
    OP_DIVU = 4'd12,
    OP_REM  = 4'd13,
    OP_REMU = 4'd14
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_iter(input md_op_e op);
    return op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Ops whose half-width operands must be sign-extended rather than zero-extended.
  function automatic logic is_signed_op(input md_op_e op);
    return op inside {OP_SRA, OP_SLT, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/exu_iter_muldiv.sv
// Iterative 1-bit-per-cycle engine: shift-add multiply and restoring divide.
// Operands arrive already truncated/extended for half-width ops.
module exu_iter_muldiv
  import exu_md_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  md_op_e          op,
  input  logic            half,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  md_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  md_op_e          op_q;
  logic            half_q;
  logic [XLEN-1:0] a_q, b_q, acc_q, opd_q, shr_q;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            fits, sgn_in, sgn_q, neg_a, neg_b;
  logic [XLEN-1:0] quo, rem, res;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  assign busy    = (state_q == ST_BUSY);
  assign done    = (state_q == ST_DONE);
  assign sgn_in  = (op == OP_DIV) || (op == OP_REM);
  assign sgn_q   = (op_q == OP_DIV) || (op_q == OP_REM);
  assign rem_sh  = {acc_q, shr_q[XLEN-1]};
  assign rem_sub = rem_sh - {1'b0, opd_q};
  assign fits    = !rem_sub[XLEN];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_BUSY;
          cnt_q   <= half ? CNT_W'(32) : CNT_W'(XLEN);
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Dividend is left-aligned so a 32-step half divide consumes only its low word.
  always_ff @(posedge clk) begin
    if (start && state_q == ST_IDLE) begin
      op_q   <= op;
      half_q <= half;
      a_q    <= a;
      b_q    <= b;
      acc_q  <= '0;
      if (op == OP_MUL) begin
        opd_q <= a;
        shr_q <= b;
      end else begin
        opd_q <= mag(b, sgn_in);
        shr_q <= half ? (mag(a, sgn_in) << (XLEN-32)) : mag(a, sgn_in);
      end
    end else if (state_q == ST_BUSY) begin
      if (op_q == OP_MUL) begin
        if (shr_q[0]) acc_q <= acc_q + opd_q;
        opd_q <= opd_q << 1;
        shr_q <= shr_q >> 1;
      end else begin
        acc_q <= fits ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        shr_q <= {shr_q[XLEN-2:0], fits};
      end
    end
  end

  // Sign fix-up and RISC-V divide corner cases, evaluated while in DONE.
  always_comb begin
    neg_a = sgn_q && a_q[XLEN-1];
    neg_b = sgn_q && b_q[XLEN-1];
    quo   = (neg_a ^ neg_b) ? -shr_q : shr_q;
    rem   = neg_a ? -acc_q : acc_q;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end else if (sgn_q && b_q == '1 && a_q == (half_q ? MIN_W : MIN_X)) begin
      quo = a_q;
      rem = '0;
    end
    if (op_q == OP_MUL)                         res = acc_q;
    else if (op_q == OP_DIV || op_q == OP_DIVU) res = quo;
    else                                        res = rem;
    result = half_q ? sext32(res[31:0]) : res;
  end

endmodule

// File: rtl/exu_md_pipe.sv
// Execute stage: single-cycle ALU, iterative MUL/DIV engine and the
// valid/ready output register feeding the memory stage.
module exu_md_pipe
  import exu_md_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_half,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SH_W = $clog2(XLEN);

  md_op_e                 op_p0;
  logic                   half_p0, sgn_p0, accept, start, md_busy, md_done;
  logic signed [XLEN-1:0] a_p0, b_p0;
  logic [SH_W-1:0]        sh_p0;
  logic [XLEN-1:0]        alu_raw, alu_p0, md_result;
  logic [TAG_W-1:0]       tag_iter_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  assign op_p0    = md_op_e'(in_op);
  assign half_p0  = in_half && (XLEN == 64);
  assign sgn_p0   = is_signed_op(op_p0);
  assign sh_p0    = half_p0 ? SH_W'(in_b[4:0]) : in_b[SH_W-1:0];
  assign in_ready = !flush && !md_busy && !md_done && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign start    = accept && is_iter(op_p0);
  assign busy     = md_busy;

  always_comb begin
    a_p0 = in_a;
    b_p0 = in_b;
    if (half_p0) begin
      a_p0 = sgn_p0 ? sext32(in_a[31:0]) : zext32(in_a[31:0]);
      b_p0 = sgn_p0 ? sext32(in_b[31:0]) : zext32(in_b[31:0]);
    end
  end

  always_comb begin
    unique case (op_p0)
      OP_SUB:  alu_raw = a_p0 - b_p0;
      OP_AND:  alu_raw = a_p0 & b_p0;
      OP_OR:   alu_raw = a_p0 | b_p0;
      OP_XOR:  alu_raw = a_p0 ^ b_p0;
      OP_SLL:  alu_raw = a_p0 << sh_p0;
      OP_SRL:  alu_raw = $unsigned(a_p0) >> sh_p0;
      OP_SRA:  alu_raw = a_p0 >>> sh_p0;
      OP_SLT:  alu_raw = XLEN'(a_p0 < b_p0);
      OP_SLTU: alu_raw = XLEN'($unsigned(a_p0) < $unsigned(b_p0));
      default: alu_raw = a_p0 + b_p0;
    endcase
    alu_p0 = half_p0 ? sext32(alu_raw[31:0]) : alu_raw;
  end

  exu_iter_muldiv #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .abort  (flush),
    .op     (op_p0),
    .half   (half_p0),
    .a      (a_p0),
    .b      (b_p0),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (start) tag_iter_q <= in_tag;
  end

  // Stage boundary p0 -> output slot; flush wins over a same-cycle completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (md_done) begin
      out_valid  <= 1'b1;
      out_result <= md_result;
      out_tag    <= tag_iter_q;
    end else if (accept && !is_iter(op_p0)) begin
      out_valid  <= 1'b1;
      out_result <= alu_p0;
      out_tag    <= in_tag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exu_md_pipe.sv
// Scoreboard bench for exu_md_pipe: stimulus pushes reference results,
// a negedge monitor pops and compares on every consumed output.
module tb_exu_md_pipe;
  import exu_md_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_op = 4'd0;
  logic             in_half = 1'b0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  typedef struct packed {
    logic [63:0] res;
    logic [15:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  exu_md_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_half    (in_half),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: RISC-V semantics written directly with SV arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input bit half,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] r32;
    logic [63:0] r64;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    sa32 = a[31:0];
    sb32 = b[31:0];
    sa64 = a;
    sb64 = b;
    if (half) begin
      case (op)
        OP_SUB:  r32 = a[31:0] - b[31:0];
        OP_AND:  r32 = a[31:0] & b[31:0];
        OP_OR:   r32 = a[31:0] | b[31:0];
        OP_XOR:  r32 = a[31:0] ^ b[31:0];
        OP_SLL:  r32 = a[31:0] << b[4:0];
        OP_SRL:  r32 = a[31:0] >> b[4:0];
        OP_SRA:  r32 = sa32 >>> b[4:0];
        OP_SLT:  r32 = (sa32 < sb32) ? 32'd1 : 32'd0;
        OP_SLTU: r32 = (a[31:0] < b[31:0]) ? 32'd1 : 32'd0;
        OP_MUL:  r32 = a[31:0] * b[31:0];
        OP_DIV:  if (sb32 == '0) r32 = '1;
                 else if (sa32 == 32'sh8000_0000 && sb32 == '1) r32 = sa32;
                 else r32 = sa32 / sb32;
        OP_DIVU: if (b[31:0] == '0) r32 = '1; else r32 = a[31:0] / b[31:0];
        OP_REM:  if (sb32 == '0) r32 = sa32;
                 else if (sa32 == 32'sh8000_0000 && sb32 == '1) r32 = '0;
                 else r32 = sa32 % sb32;
        OP_REMU: if (b[31:0] == '0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = a[31:0] + b[31:0];
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (op)
      OP_SUB:  r64 = a - b;
      OP_AND:  r64 = a & b;
      OP_OR:   r64 = a | b;
      OP_XOR:  r64 = a ^ b;
      OP_SLL:  r64 = a << b[5:0];
      OP_SRL:  r64 = a >> b[5:0];
      OP_SRA:  r64 = sa64 >>> b[5:0];
      OP_SLT:  r64 = (sa64 < sb64) ? 64'd1 : 64'd0;
      OP_SLTU: r64 = (a < b) ? 64'd1 : 64'd0;
      OP_MUL:  r64 = a * b;
      OP_DIV:  if (sb64 == '0) r64 = '1;
               else if (sa64 == 64'sh8000_0000_0000_0000 && sb64 == '1) r64 = sa64;
               else r64 = sa64 / sb64;
      OP_DIVU: if (b == '0) r64 = '1; else r64 = a / b;
      OP_REM:  if (sb64 == '0) r64 = sa64;
               else if (sa64 == 64'sh8000_0000_0000_0000 && sb64 == '1) r64 = '0;
               else r64 = sa64 % sb64;
      OP_REMU: if (b == '0) r64 = a; else r64 = a % b;
      default: r64 = a + b;
    endcase
    return r64;
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input bit half, input logic [63:0] a,
                      input logic [63:0] b, input logic [15:0] tag, output int waited);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_half  = half;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("accept_in_time", 64'(in_ready), 64'd1);
    if (in_ready) begin
      e.res = model(op, half, a, b);
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", out_result, e.res);
        check("tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, n;
    logic [63:0] exp_res;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops
    send(OP_ADD, 0, 64'd5, 64'd7, 16'h0001, w);
    send(OP_SUB, 0, 64'd3, 64'd5, 16'h0002, w2);
    check("b2b_ready_1", 64'(w), 64'd0);
    check("b2b_ready_2", 64'(w2), 64'd0);
    send(OP_ADD, 1, 64'h7FFF_FFFF, 64'd1, 16'h0003, w);
    drain();

    // DIVU latency: 64 busy cycles, result at accept+65
    send(OP_DIVU, 0, 64'd100, 64'd7, 16'h0010, w);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy && !in_ready && !out_valid) n++;
    end
    check("divu_busy_cycles", 64'(n), 64'd64);
    @(negedge clk);
    check("divu_not_early", 64'({busy, out_valid}), 64'd0);
    @(negedge clk);
    check("divu_valid_at_65", 64'(out_valid), 64'd1);
    drain();
    send(OP_REMU, 0, 64'd100, 64'd7, 16'h0011, w);
    drain();

    // Division corner cases
    send(OP_DIV,  0, -64'sd9, 64'd0, 16'h0020, w);
    send(OP_REM,  0, 64'h8000_0000_0000_0000, '1, 16'h0021, w);
    send(OP_DIV,  0, 64'h8000_0000_0000_0000, '1, 16'h0022, w);
    send(OP_REMU, 0, 64'd77, 64'd0, 16'h0023, w);
    send(OP_DIV,  1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 16'h0024, w);
    send(OP_REM,  1, 64'h0000_0000_FFFF_FFF7, 64'hABCD_0000_0000_0000, 16'h0025, w);
    drain();

    // Flush during a multiply
    send(OP_MUL, 0, 64'd3, 64'd4, 16'h0030, w);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("flush_no_result", 64'(n), 64'd0);
    @(posedge clk);
    #1;

    // Flush with in_valid accepts nothing
    flush = 1'b1;
    in_valid = 1'b1;
    in_op = OP_ADD;
    in_half = 1'b0;
    in_a = 64'd1;
    in_b = 64'd1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_no_accept", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Flush coinciding with completion
    send(OP_DIVU, 0, 64'd50, 64'd5, 16'h0031, w);
    repeat (64) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid || busy) n++;
    end
    check("flush_beats_done", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    send(OP_ADD, 0, 64'd2, 64'd3, 16'h0032, w);
    drain();

    // Stall holds output stable and blocks input
    out_ready = 1'b0;
    send(OP_XOR, 0, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 16'hBEEF, w);
    exp_res = model(OP_XOR, 0, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_result", out_result, exp_res);
      check("stall_tag", 64'(out_tag), 64'hBEEF);
      check("stall_in_ready", 64'({out_valid, in_ready}), 64'd2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-divide
    send(OP_DIV, 0, 64'd1000, 64'd3, 16'h0040, w);
    repeat (20) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out_result", out_result, 64'd0);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid || busy) n++;
    end
    check("arst_no_partial", 64'(n), 64'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), rnd_opnd(), rnd_opnd(),
           16'($urandom), w);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_md_pipe.md
Name: exu_md_pipe

Overview:
- Parametrised execute stage and pipeline register, replacing the fixed 64-bit single-cycle EX register.
- Single-cycle integer ALU ops complete in 1 cycle.
- MUL/DIV/REM run on an iterative 1-bit-per-cycle engine.
- Sits between decode/operand-forwarding and the memory stage; uses valid/ready handshakes on both sides and a flush input for branch redirect.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TAG_W, 16, width of the opaque side-band (rd index, wb_en, load/store controls) carried alongside the result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  kill the in-flight op and the output slot.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept an op this cycle.
- in_op  in  4  opcode; encodings in exu_md_pkg.
- in_half  in  1  32-bit (W) variant; ignored when XLEN==32.
- in_a  in  XLEN  operand A, already forwarded/muxed.
- in_b  in  XLEN  operand B, already forwarded/muxed.
- in_tag  in  TAG_W  side-band, passed through unchanged.
- out_valid  out  1  result slot full.
- out_ready  in  1  downstream consumes the slot.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  side-band of the result.
- busy  out  1  iterative engine active.

Behaviour:
- Reset, asynchronous on rstn low:
  - state=IDLE
  - out_valid=0, out_result=0, out_tag=0
  - busy=0, iteration counter=0
- Ops:
  - Single-cycle: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Iterative: MUL (low XLEN bits), DIV, DIVU, REM, REMU.
  - Unused encodings behave as ADD.
- Handshake:
  - in_ready = !flush && state==IDLE && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Single-cycle latency:
  - Op accepted at edge N → out_valid=1 with result from edge N.
  - Holds until consumed; back-to-back ops sustain 1 op/cycle.
- Iterative FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY on accept of an iterative op. Operands are latched, counter loads ITER = in_half ? 32 : XLEN.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle. Counter decrements; busy=1.
  - BUSY→DONE when the counter reaches 1.
  - DONE: writes out_result/out_tag, sets out_valid, →IDLE in the same edge.
  - Accept at N → out_valid at edge N+ITER+1.
  - The output slot is guaranteed empty at completion, because no accept occurs while BUSY.
- Width rules:
  - Shift amount is in_b[log2(XLEN)-1:0], or in_b[4:0] when half.
  - Half ops: operands truncated to 32 bits, sign- or zero-extended per signedness. Result[31:0] is sign-extended to XLEN.
  - SLT/SLTU return 0 or 1.
- Division corner cases (RISC-V):
  - Divide by zero: quotient=all-ones, remainder=dividend.
  - Signed overflow (MIN / -1): quotient=MIN, remainder=0.
  - Both are resolved in the DONE step without an early exit; latency is unchanged.
- Flush:
  - At the next edge, out_valid=0, state=IDLE, busy=0, and any iterative op is aborted with no result.
  - in_ready=0 while flush is high, so flush plus in_valid accepts nothing.
  - Flush outranks completion in the same cycle.
- Reset mid-operation: asynchronous clear of all state per the reset list; no partial result escapes.
- Stall: while out_valid && !out_ready, out_result/out_tag are stable.

Decomposition:
- exu_md_pkg:
  - op enum (OP_ADD..OP_REMU, 4 bits)
  - FSM state enum
  - helper function is_iter(op)
- Sub-module exu_iter_muldiv, parametrised by XLEN:
  - Contains the counter and the shift/subtract datapath.
  - Interface: start/op/half/a/b in; done/result out.
  - abort input driven by flush.
- The top contains the single-cycle ALU, the handshake and the output register.

Test Plan:
1. XLEN=64, ADD a=5,b=7 then SUB a=3,b=5 on consecutive cycles, out_ready=1 → results 12 then 0xFFFF_FFFF_FFFF_FFFE on consecutive cycles; in_ready stays 1.
2. ADDW (half) a=0x7FFF_FFFF, b=1 → out_result=0xFFFF_FFFF_8000_0000 one cycle after accept.
3. DIVU a=100, b=7 → in_ready=0 and busy=1 for 64 cycles; out_valid at accept+65 with result 14. REMU on the same operands gives 2.
4. DIV by 0 with a=-9 → quotient 0xFFFF_FFFF_FFFF_FFFF. REM a=MIN, b=-1 → 0. DIV a=MIN, b=-1 → MIN.
5. Start MUL 3×4, assert flush at cycle 10 of BUSY → busy=0 and out_valid=0 next edge, no result ever appears. The next ADD is accepted normally.
6. out_ready=0 for 5 cycles after a result → out_result/out_tag stable, in_ready=0. Drop rstn mid-DIV → all outputs 0 immediately, without waiting for a clock edge.
